// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the bin2bcd conversion path: arbiter FSM states,
// default widths and the bin2bcd peripheral register map.
package bin2bcd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_e;

   localparam int unsigned W_IN_DEF  = 16;
   localparam int unsigned W_BCD_DEF = 20;

   // Register offsets of the bin2bcd peripheral
   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_OPERAND = 8'h04;
   localparam logic [7:0] REG_RESULT  = 8'h08;
   localparam logic [7:0] REG_STATUS  = 8'h0C;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping modulo N_REQ. Returns one-hot grant and its index.
module rr_arbiter
   import bin2bcd_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    idx_o,
   output logic             valid_o
);

   // Scan requests starting at the pointer; the first hit wins
   always_comb begin
      logic [IW-1:0] jx;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      jx      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         jx = IW'((32'(ptr_i) + k) % N_REQ);
         if (!valid_o && req_i[jx]) begin
            valid_o   = 1'b1;
            gnt_o[jx] = 1'b1;
            idx_o     = jx;
         end
      end
   end

endmodule

// File: rtl/bin2bcd_arbiter.sv
// Shares one bin2bcd core between N_REQ requesters. Round-robin grant,
// operand capture, init/done handshake with stale-done masking, timeout abort
// and one-cycle response pulse back to the granted requester.
module bin2bcd_arbiter
   import bin2bcd_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned W_IN    = W_IN_DEF,
   parameter int unsigned W_BCD   = W_BCD_DEF,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*W_IN-1:0]   a_flat,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [W_BCD-1:0]        rsp_bcd,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [W_IN-1:0]         core_a,
   output logic                    core_init,
   input  logic                    core_done,
   input  logic [W_BCD-1:0]        core_result
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

   state_e            state_q;
   logic [IW-1:0]     ptr_q;
   logic [IW-1:0]     grant_idx_q;
   logic [N_REQ-1:0]  grant_oh_q;
   logic [CW-1:0]     cnt_q;
   logic              done_low_q;
   logic [W_IN-1:0]   core_a_q;
   logic [W_BCD-1:0]  rsp_bcd_q;
   logic              rsp_err_q;
   logic [N_REQ-1:0]  ack_q;
   logic [N_REQ-1:0]  rsp_valid_q;
   logic              init_q;

   logic [N_REQ-1:0]  arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic              arb_valid;
   logic [W_IN-1:0]   a_win_d;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Operand of the current arbitration winner
   always_comb begin
      a_win_d = a_flat[arb_idx*W_IN +: W_IN];
   end

   // Transaction FSM; ack/init/rsp_valid are set on entry to LOAD/START/RESP
   // so each is high for exactly the cycle spent in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         cnt_q       <= '0;
         done_low_q  <= 1'b0;
         core_a_q    <= '0;
         rsp_bcd_q   <= '0;
         rsp_err_q   <= 1'b0;
         ack_q       <= '0;
         rsp_valid_q <= '0;
         init_q      <= 1'b0;
      end else begin
         ack_q       <= '0;
         rsp_valid_q <= '0;
         init_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  grant_idx_q <= arb_idx;
                  grant_oh_q  <= arb_gnt;
                  core_a_q    <= a_win_d;
                  ack_q       <= arb_gnt;
                  state_q     <= LOAD;
               end
            end
            LOAD: begin
               init_q  <= 1'b1;
               state_q <= START;
            end
            START: begin
               cnt_q      <= '0;
               done_low_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // A done level still high from the previous conversion is
               // ignored until done has been seen low at least once.
               if (!core_done) begin
                  done_low_q <= 1'b1;
               end
               if (core_done && done_low_q) begin
                  rsp_bcd_q   <= core_result;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= grant_oh_q;
                  state_q     <= RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_bcd_q   <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= grant_oh_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               ptr_q   <= (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_bcd   = rsp_bcd_q;
   assign rsp_err   = rsp_err_q;
   assign core_a    = core_a_q;
   assign core_init = init_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bin2bcd_arbiter.sv
// Bench for bin2bcd_arbiter with a behavioural conversion core and a
// response scoreboard checked on every rsp_valid pulse.
module tb_bin2bcd_arbiter;

   localparam int N_REQ   = 4;
   localparam int W_IN    = 16;
   localparam int W_BCD   = 20;
   localparam int TIMEOUT = 32;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_REQ-1:0]      req;
   logic [N_REQ*W_IN-1:0] a_flat;
   logic [N_REQ-1:0]      ack;
   logic [N_REQ-1:0]      rsp_valid;
   logic [W_BCD-1:0]      rsp_bcd;
   logic                  rsp_err;
   logic                  busy;
   logic [W_IN-1:0]       core_a;
   logic                  core_init;
   logic                  core_done = 1'b0;
   logic [W_BCD-1:0]      core_result = '0;

   bin2bcd_arbiter #(
      .N_REQ   (N_REQ),
      .W_IN    (W_IN),
      .W_BCD   (W_BCD),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .a_flat      (a_flat),
      .ack         (ack),
      .rsp_valid   (rsp_valid),
      .rsp_bcd     (rsp_bcd),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .core_a      (core_a),
      .core_init   (core_init),
      .core_done   (core_done),
      .core_result (core_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned      idx;
      logic [W_BCD-1:0] bcd;
      logic             err;
      int unsigned      due;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   logic [N_REQ-1:0] mon_oh;
   int unsigned      total_cnt = 0;
   int unsigned      pass_cnt  = 0;
   int unsigned      cyc       = 0;
   bit               mon_en    = 1'b0;
   logic [N_REQ-1:0] prev_ack  = '0;

   // Behavioural core configuration
   int unsigned k_cfg     = 5;
   int unsigned stale_cfg = 0;
   bit          never     = 1'b0;
   int unsigned ccnt      = 0;
   int unsigned chold     = 0;

   function automatic logic [W_BCD-1:0] to_bcd(input logic [W_IN-1:0] v);
      logic [W_BCD-1:0] r;
      int unsigned      x;
      r = '0;
      x = v;
      for (int d = 0; d < W_BCD / 4; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Core: done rises k_cfg edges after init is sampled and stays high until
   // the next init; with stale_cfg != 0 the old done level survives init for
   // stale_cfg edges.
   always @(posedge clk) begin
      if (core_init) begin
         ccnt  <= k_cfg;
         chold <= stale_cfg;
         if (stale_cfg == 0) core_done <= 1'b0;
      end else begin
         if (chold != 0) begin
            chold <= chold - 1;
            if (chold == 1) core_done <= 1'b0;
         end
         if (ccnt > 1) begin
            ccnt <= ccnt - 1;
         end else if (ccnt == 1) begin
            ccnt <= 0;
            if (!never) begin
               core_done   <= 1'b1;
               core_result <= to_bcd(core_a);
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle invariants and scoreboard pop on every response pulse
   always @(negedge clk) begin
      if (mon_en) begin
         total_cnt++;
         if ($onehot0(ack) && $onehot0(rsp_valid) && (!core_init || busy) &&
             (core_init === (prev_ack != 0)) && ((ack == 0 && rsp_valid == 0) || busy))
            pass_cnt++;
         else
            $display("FAIL invariant cyc=%0d ack=%b rsp_valid=%b core_init=%b busy=%b prev_ack=%b",
                     cyc, ack, rsp_valid, core_init, busy, prev_ack);
         prev_ack = ack;
         if (rsp_valid != 0) begin
            total_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_rsp cyc=%0d rsp_valid=%b bcd=%h err=%b required no response",
                        cyc, rsp_valid, rsp_bcd, rsp_err);
            end else begin
               mon_e  = sb.pop_front();
               mon_oh = '0;
               mon_oh[mon_e.idx] = 1'b1;
               if (rsp_valid === mon_oh && rsp_bcd === mon_e.bcd && rsp_err === mon_e.err &&
                   cyc == mon_e.due)
                  pass_cnt++;
               else
                  $display("FAIL rsp got valid=%b bcd=%h err=%b cyc=%0d required valid=%b bcd=%h err=%b cyc=%0d",
                           rsp_valid, rsp_bcd, rsp_err, cyc, mon_oh, mon_e.bcd, mon_e.err, mon_e.due);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset  = 1'b1;
      req    = '0;
      a_flat = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({ack, rsp_valid, core_init} !== '0) $display("FAIL reset_pulses ack=%b rsp_valid=%b init=%b required 0", ack, rsp_valid, core_init);
      else pass_cnt++;
      total_cnt++;
      if ({rsp_bcd, rsp_err, core_a} !== '0) $display("FAIL reset_data bcd=%h err=%b core_a=%h required 0", rsp_bcd, rsp_err, core_a);
      else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      k_cfg = 18;
      a_flat[0 +: W_IN] = 16'd1234;
      req = 4'b0001;
      sb.push_back('{0, 20'h01234, 1'b0, cyc + 4 + 18});
      @(negedge clk);
      total_cnt++;
      if (ack !== 4'b0001 || busy !== 1'b1) $display("FAIL single_ack ack=%b busy=%b required 0001 1", ack, busy);
      else pass_cnt++;
      req = '0;
      a_flat[0 +: W_IN] = 16'd9999;
      @(negedge clk);
      total_cnt++;
      if (core_a !== 16'd1234) $display("FAIL single_core_a got %0d required 1234", core_a);
      else pass_cnt++;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL single_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (rsp_bcd !== 20'h01234 || rsp_err !== 1'b0 || busy !== 1'b0)
         $display("FAIL single_hold bcd=%h err=%b busy=%b required 01234 0 0", rsp_bcd, rsp_err, busy);
      else pass_cnt++;
   endtask

   task automatic test_rotation();
      int unsigned      n0;
      int unsigned      dues[5];
      int unsigned      ids[5]  = '{0, 1, 2, 3, 0};
      logic [W_BCD-1:0] bcds[5] = '{20'h00000, 20'h00009, 20'h65535, 20'h00100, 20'h00000};
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      k_cfg = 5;
      a_flat = {16'd100, 16'd65535, 16'd9, 16'd0};
      req = '1;
      n0 = cyc;
      for (int i = 0; i < 5; i++) begin
         dues[i] = n0 + 4 + 5 + i * (5 + 5);
         sb.push_back('{ids[i], bcds[i], 1'b0, dues[i]});
      end
      for (int i = 0; i < 200 && cyc != dues[3] + 2; i++) @(negedge clk);
      total_cnt++;
      if (ack !== 4'b0001) $display("FAIL rotation_fifth_ack ack=%b required 0001", ack);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL rotation_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_stale_done();
      k_cfg     = 8;
      stale_cfg = 3;
      a_flat[1*W_IN +: W_IN] = 16'd4321;
      req = 4'b0010;
      sb.push_back('{1, 20'h04321, 1'b0, cyc + 4 + 8});
      @(negedge clk);
      total_cnt++;
      if (ack !== 4'b0010) $display("FAIL stale_ack ack=%b required 0010", ack);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL stale_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      stale_cfg = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      never = 1'b1;
      k_cfg = 4;
      a_flat[1*W_IN +: W_IN] = 16'd77;
      req = 4'b0010;
      sb.push_back('{1, 20'h00000, 1'b1, cyc + 3 + TIMEOUT});
      @(negedge clk);
      total_cnt++;
      if (ack !== 4'b0010) $display("FAIL timeout_ack ack=%b required 0010", ack);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL timeout_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      @(negedge clk);
      never = 1'b0;
      a_flat[3*W_IN +: W_IN] = 16'd4095;
      req = 4'b1000;
      sb.push_back('{3, 20'h04095, 1'b0, cyc + 4 + 4});
      @(negedge clk);
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL after_timeout_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int unsigned n;
      k_cfg = 20;
      a_flat[2*W_IN +: W_IN] = 16'd321;
      req = 4'b0100;
      sb.push_back('{2, 20'h00321, 1'b0, cyc + 4 + 20});
      @(negedge clk);
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      // pointer now 3; abort a transaction for requester 3 during WAIT
      a_flat[3*W_IN +: W_IN] = 16'd500;
      req = 4'b1000;
      n = cyc;
      @(negedge clk);
      total_cnt++;
      if (ack !== 4'b1000) $display("FAIL abort_ack ack=%b required 1000", ack);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 20 && cyc != n + 5; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({ack, rsp_valid, core_init, busy, rsp_err, rsp_bcd, core_a} !== '0)
         $display("FAIL mid_reset_outputs ack=%b rv=%b init=%b busy=%b err=%b bcd=%h core_a=%h required all 0",
                  ack, rsp_valid, core_init, busy, rsp_err, rsp_bcd, core_a);
      else pass_cnt++;
      reset = 1'b0;
      repeat (30) @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL post_reset_idle busy=%b required 0", busy);
      else pass_cnt++;
      k_cfg = 3;
      a_flat[2*W_IN +: W_IN] = 16'd777;
      a_flat[3*W_IN +: W_IN] = 16'd888;
      req = 4'b1100;
      n = cyc;
      sb.push_back('{2, 20'h00777, 1'b0, n + 7});
      sb.push_back('{3, 20'h00888, 1'b0, n + 15});
      @(negedge clk);
      total_cnt++;
      if (ack !== 4'b0100) $display("FAIL post_reset_grant ack=%b required 0100", ack);
      else pass_cnt++;
      for (int i = 0; i < 20 && cyc != n + 9; i++) @(negedge clk);
      total_cnt++;
      if (ack !== 4'b1000) $display("FAIL post_reset_second ack=%b required 1000", ack);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb.size() != 0) $display("FAIL post_reset_drain pending=%0d required 0", sb.size());
      else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_stale_done();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
